// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned DIV_WIDTH = 32;

  localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/seq_divider_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, trial-subtract.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_dsr,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_trial;
  logic             w_fits;

  assign w_shift = {i_rem, i_bit};
  assign w_fits  = w_shift >= {1'b0, i_dsr};
  // When the divisor fits, the difference is below the divisor, so the low WIDTH bits are exact.
  assign w_trial = w_shift[WIDTH-1:0] - i_dsr;

  assign o_q   = w_fits;
  assign o_rem = w_fits ? w_trial : w_shift[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle DIV/DIVU unit: one quotient bit per cycle, sign fix-up after the unsigned core.
// Optional SEQ_DIVIDER_DBZ_FLAG_EN adds a sticky div_by_zero output.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
  ,
  output logic             div_by_zero
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dsr;
  logic             r_qneg;
  logic             r_rneg;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;
  logic             r_dbz;

  logic             w_accept;
  logic             w_zero;
  logic             w_last;
  logic             w_dvd_neg;
  logic             w_dsr_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dsr_mag;
  logic [WIDTH-1:0] w_rem_nxt;
  logic             w_qbit;

  assign w_accept  = (r_state == IDLE) && start;
  assign w_zero    = (divisor == '0);
  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_dvd_neg = is_signed && dividend[WIDTH-1];
  assign w_dsr_neg = is_signed && divisor[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? -dividend : dividend;
  assign w_dsr_mag = w_dsr_neg ? -divisor : divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_bit (r_dvd[WIDTH-1]),
    .i_dsr (r_dsr),
    .o_rem (w_rem_nxt),
    .o_q   (w_qbit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (start) w_next = w_zero ? DONE : CALC;
      CALC: if (w_last) w_next = FIX;
      FIX:  w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_rem  <= '0;
      r_dvd  <= '0;
      r_dsr  <= '0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
      r_quot <= '0;
      r_remo <= '0;
      r_dbz  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt  <= '0;
        r_rem  <= '0;
        r_dvd  <= w_dvd_mag;
        r_dsr  <= w_dsr_mag;
        r_qneg <= w_dvd_neg ^ w_dsr_neg;
        r_rneg <= w_dvd_neg;
        r_dbz  <= w_zero;
        if (w_zero) begin
          r_quot <= {WIDTH{DBZ_QUOTIENT[0]}};
          r_remo <= dividend;
        end
      end else if (r_state == CALC) begin
        r_rem <= w_rem_nxt;
        r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
        r_cnt <= r_cnt + 1'b1;
      end else if (r_state == FIX) begin
        r_quot <= r_qneg ? -r_dvd : r_dvd;
        r_remo <= r_rneg ? -r_rem : r_rem;
      end
    end
  end

  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign quotient  = r_quot;
  assign remainder = r_remo;

`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
  assign div_by_zero = r_dbz;
`else
  logic w_dbz_unused;
  assign w_dbz_unused = r_dbz;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus random DIV/DIVU against an arithmetic model.
module tb_seq_divider;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
  logic        div_by_zero;
`endif

  int tests = 0;
  int fails = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
    ,
    .div_by_zero (div_by_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Truncating division computed with 64-bit arithmetic so the signed overflow case is well defined.
  function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      return;
    end
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = 32'(sa / sb);
    r = 32'(sa % sb);
  endfunction

  // chain: start already high with operands a/b, just wait for the accept edge.
  // inj: cycle at which a competing start pulse is driven (0 = none).
  // hold: leave start high with the same operands during the done cycle.
  task automatic run(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                     input int inj, input bit chain, input bit hold);
    logic [31:0] eq, er;
    int lat, cyc;
    bit busy_ok;
    model(s, a, b, eq, er);
    lat = (b == 32'd0) ? 1 : 34;
    if (!chain) begin
      @(negedge clk);
      start = 1'b1; is_signed = s; dividend = a; divisor = b;
    end
    @(posedge clk); #1;
    start = 1'b0; is_signed = $urandom_range(0, 1); dividend = $urandom; divisor = $urandom;
    cyc = 1;
    busy_ok = 1'b1;
    while (!done && cyc < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (inj != 0 && cyc == inj) begin
        start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3;
      end
      if (inj != 0 && cyc == inj + 1) start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " done"}, {63'd0, done}, 64'd1);
    chk({tag, " latency"}, 64'(cyc), 64'(lat));
    chk({tag, " busy"}, {62'd0, busy_ok, busy}, 64'd3);
    chk({tag, " quotient"}, {32'd0, quotient}, {32'd0, eq});
    chk({tag, " remainder"}, {32'd0, remainder}, {32'd0, er});
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
    chk({tag, " dbz flag"}, {63'd0, div_by_zero}, {63'd0, (b == 32'd0)});
`endif
    if (hold) begin
      start = 1'b1; is_signed = s; dividend = a; divisor = b;
    end
    @(posedge clk); #1;
    chk({tag, " done pulse"}, {63'd0, done}, 64'd0);
    chk({tag, " idle"}, {63'd0, busy}, 64'd0);
    chk({tag, " hold q"}, {32'd0, quotient}, {32'd0, eq});
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    int          cyc;
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset done", {63'd0, done}, 64'd0);
    chk("reset q", {32'd0, quotient}, 64'd0);
    chk("reset r", {32'd0, remainder}, 64'd0);
    @(negedge clk); reset = 1'b0;

    run("divu 100/7", 1'b0, 32'd100, 32'd7, 0, 1'b0, 1'b0);
    run("div -100/7", 1'b1, 32'hFFFF_FF9C, 32'd7, 0, 1'b0, 1'b0);
    run("div 100/-7", 1'b1, 32'd100, 32'hFFFF_FFF9, 0, 1'b0, 1'b0);
    run("div ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, 1'b0);
    run("divu dbz", 1'b0, 32'h1234_5678, 32'd0, 0, 1'b0, 1'b0);
    run("div dbz neg", 1'b1, 32'h8765_4321, 32'd0, 0, 1'b0, 1'b0);
    run("ignored start", 1'b0, 32'd100, 32'd7, 10, 1'b0, 1'b0);
    run("start at done", 1'b1, 32'hFFFF_FC18, 32'd13, 0, 1'b0, 1'b1);
    run("accept after done", 1'b1, 32'hFFFF_FC18, 32'd13, 0, 1'b1, 1'b0);
    run("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 0, 1'b0, 1'b0);
    run("divu small/big", 1'b0, 32'd5, 32'hFFFF_FFFF, 0, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      rs = $urandom_range(0, 1);
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
      if (i == 4) rb = 32'hFFFF_FFFF;
      run("random", rs, ra, rb, 0, 1'b0, 1'b0);
    end

    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 15) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("pre-reset busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    #1;
    chk("async reset busy", {63'd0, busy}, 64'd0);
    chk("async reset done", {63'd0, done}, 64'd0);
    chk("async reset q", {32'd0, quotient}, 64'd0);
    chk("async reset r", {32'd0, remainder}, 64'd0);
    @(negedge clk); reset = 1'b0;
    run("divu 9/3 after reset", 1'b0, 32'd9, 32'd3, 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle 32-bit integer divider for the MIPS execute stage; serves DIV and DIVU.
- Produces quotient (LO) and remainder (HI) by restoring shift-subtract, one quotient bit per cycle.
- Performs the inverse of the adder datapath: repeated trial subtraction instead of carry-propagated addition.
- Sits beside the ALU; the pipeline stalls on busy and writes HI/LO on done.

Parameters:
- WIDTH, 32, operand/result width in bits; must be at least 2.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a division; sampled only in IDLE.
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- dividend  input  WIDTH  numerator; sampled with start.
- divisor  input  WIDTH  denominator; sampled with start.
- busy  output  1  high from the cycle after start is accepted until done has fallen.
- done  output  1  one-cycle pulse; quotient and remainder are valid from this cycle.
- quotient  output  WIDTH  result for LO; held until the next accepted start.
- remainder  output  WIDTH  result for HI; held until the next accepted start.

Interface decision: one clock, clk. reset is asynchronous and active-high.

Behaviour:
- Reset, at any time including mid-operation:
  - state = IDLE; busy = 0, done = 0, quotient = 0, remainder = 0, iteration counter = 0.
  - Any in-flight division is discarded.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start = 1 with divisor != 0 → latch operands into internal registers, go to CALC, counter = 0.
  - For signed operations, store operand magnitudes plus a quotient sign (sign(dividend) XOR sign(divisor)) and a remainder sign (sign(dividend)).
- CALC, once per cycle:
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor magnitude using a WIDTH+1-bit subtraction.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - After WIDTH iterations (counter = WIDTH-1), go to FIX.
- FIX:
  - Negate the quotient if its sign bit is set; negate the remainder if its sign bit is set.
  - Register both onto the outputs, then go to DONE.
- DONE: done = 1 for exactly one cycle, then return to IDLE. busy falls together with done.
- Latency: done is high WIDTH+2 cycles after the start-accept edge (34 cycles for WIDTH = 32).
- Divide by zero:
  - IDLE → DONE directly; quotient = all ones, remainder = dividend (unmodified, for both signednesses).
  - done is high 1 cycle after the accept edge.
- Signed overflow (dividend = 0x80000000, divisor = -1): quotient = 0x80000000, remainder = 0. This falls out of the unsigned core with no special case.
- Remainder sign always follows the dividend (truncating division, MIPS semantics).
- start while busy is ignored; no queuing.
- start in the same cycle as done is ignored; it is accepted in the following IDLE cycle.
- Outputs change only in FIX, on a divide-by-zero accept, or on reset.

Optional Feature:
- Macro: SEQ_DIVIDER_DBZ_FLAG_EN.
- Defined:
  - Adds output port div_by_zero (1 bit, reset 0).
  - Set with the divide-by-zero result, held until the next accepted start, cleared when that start is accepted.
- Undefined: the port is absent; the divide-by-zero result values are unchanged.

Decomposition:
- Package div_pkg holds:
  - the state enumeration (IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3);
  - the default WIDTH constant;
  - the divide-by-zero quotient constant (all ones).
- One natural sub-module, div_step: the combinational single-iteration restoring step.
  - Inputs: partial remainder, next dividend bit, divisor magnitude.
  - Outputs: next partial remainder and quotient bit.
  - Instantiated once in CALC.

Test Plan:
- DIVU 100 / 7 → done at cycle 34 after accept; quotient = 14, remainder = 2; busy high for cycles 1–34.
- DIV -100 / 7 → quotient = 0xFFFFFFF2 (-14), remainder = 0xFFFFFFFE (-2).
- DIV 100 / -7 → quotient = -14, remainder = 2.
- DIV 0x80000000 / 0xFFFFFFFF → quotient = 0x80000000, remainder = 0.
- DIVU 0x12345678 / 0:
  - done 1 cycle after accept; quotient = 0xFFFFFFFF, remainder = 0x12345678.
  - With SEQ_DIVIDER_DBZ_FLAG_EN, div_by_zero = 1 until the next start.
- Second start pulse at cycle 10 of a running division → ignored, first result intact.
- reset asserted at cycle 15 of a division → busy, done, quotient and remainder go to 0 immediately.
- Fresh DIVU 9 / 3 after that reset → quotient = 3, remainder = 0.
